// File: rtl/pcm_serial_pkg.sv
// Shared types and helpers for the PCM/TDM serializer.
package pcm_serial_pkg;

  typedef enum logic {
    PCM_MODE_LJ,
    PCM_MODE_I2S
  } pcm_mode_e;

  typedef enum logic {
    SER_IDLE,
    SER_RUN
  } ser_state_e;

  function automatic int frame_bits(input int channels, input int slot_width);
    return channels * slot_width;
  endfunction

endpackage

// File: rtl/pcm_frame_fifo.sv
// Synchronous frame FIFO with show-ahead head word and registered occupancy.
module pcm_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                           bit_clock_in,
  input  logic                           rst_active_high,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Head is read combinationally so a pop can land in the shift register on the same edge.
  assign rd_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge bit_clock_in) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge bit_clock_in) begin
    if (rst_active_high) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/pcm_tdm_serializer.sv
// N-channel PCM-to-serial DAC driver with frame FIFO, LJ or I2S framing.
module pcm_tdm_serializer
  import pcm_serial_pkg::*;
#(
  parameter int        SAMPLE_WIDTH = 16,
  parameter int        SLOT_WIDTH   = 16,
  parameter int        CHANNELS     = 2,
  parameter int        FIFO_DEPTH   = 4,
  parameter pcm_mode_e MODE         = PCM_MODE_LJ
) (
  input  logic                                bit_clock_in,
  input  logic                                rst_active_high,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0]    frame_data,
  input  logic                                frame_valid,
  output logic                                frame_ready,
  input  logic                                enable,
  output logic                                serial_data_out,
  output logic                                bit_clock_out,
  output logic                                LR_select,
  output logic                                underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

  localparam int FRAME_BITS = frame_bits(CHANNELS, SLOT_WIDTH);
  localparam int HALF_BITS  = FRAME_BITS / 2;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam int DATA_W     = CHANNELS * SAMPLE_WIDTH;

  ser_state_e            state_reg, state_next;
  logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic                  i2s_dly_reg;
  logic                  lr_reg, lr_next;
  logic                  underrun_reg, underrun_next;

  logic                  load;
  logic                  last_bit;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_W-1:0]     fifo_head;
  logic [FRAME_BITS-1:0] padded_head;

  assign bit_clock_out = bit_clock_in;
  assign frame_ready   = !fifo_full;

  pcm_frame_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .bit_clock_in    (bit_clock_in),
    .rst_active_high (rst_active_high),
    .push            (frame_valid && frame_ready),
    .wr_data         (frame_data),
    .pop             (load && !fifo_empty),
    .rd_data         (fifo_head),
    .full            (fifo_full),
    .empty           (fifo_empty),
    .level           (fifo_level)
  );

  // Each sample sits left-aligned in its slot; the low pad bits are zero.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : gen_pad
      assign padded_head[gi*SLOT_WIDTH +: SLOT_WIDTH] =
        SLOT_WIDTH'(fifo_head[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH]) << (SLOT_WIDTH - SAMPLE_WIDTH);
    end
  endgenerate

  assign last_bit = (bit_idx_reg == IDX_W'(FRAME_BITS - 1));

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      SER_IDLE: begin
        if (enable) begin
          load       = 1'b1;
          state_next = SER_RUN;
        end
      end
      SER_RUN: begin
        if (last_bit) begin
          if (enable) load = 1'b1;
          else        state_next = SER_IDLE;
        end
      end
      default: state_next = SER_IDLE;
    endcase

    bit_idx_next = '0;
    if (state_reg == SER_RUN && !last_bit && !load) begin
      bit_idx_next = bit_idx_reg + IDX_W'(1);
    end

    shift_next = shift_reg;
    if (load) begin
      shift_next = fifo_empty ? '0 : padded_head;
    end else if (state_reg == SER_RUN) begin
      // Zero fill leaves the register clear after the final shift of a frame.
      shift_next = shift_reg << 1;
    end

    lr_next       = (state_next == SER_RUN) && (bit_idx_next >= IDX_W'(HALF_BITS));
    underrun_next = load && fifo_empty;
  end

  always_ff @(posedge bit_clock_in) begin
    if (rst_active_high) begin
      state_reg    <= SER_IDLE;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      i2s_dly_reg  <= 1'b0;
      lr_reg       <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      i2s_dly_reg  <= shift_reg[FRAME_BITS-1];
      lr_reg       <= lr_next;
      underrun_reg <= underrun_next;
    end
  end

  assign serial_data_out = (MODE == PCM_MODE_I2S) ? i2s_dly_reg : shift_reg[FRAME_BITS-1];
  assign LR_select       = lr_reg;
  assign underrun        = underrun_reg;

endmodule
